// File: rtl/exc_commit_ctrl_pkg.sv
// Shared types and cause codes for the writeback commit/exception controller.
package cpuDefine;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDLE  = 2'd1,
    DRAIN = 2'd2
  } exc_state_t;

  // One-hot redirect/commit event chosen for the WB instruction.
  typedef struct packed {
    logic intr;
    logic exc;
    logic ertn;
    logic refetch;
    logic idle;
  } exc_event_t;

  localparam logic [5:0] INT  = 6'h00;
  localparam logic [5:0] ALE  = 6'h09;
  localparam logic [5:0] TLBR = 6'h3F;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// WB-stage inputs, CSR-facing pulses and pipeline control of the commit controller.
interface exc_commit_ctrl_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_exc_valid;
  logic [5:0]  wb_excode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_badv;
  logic        wb_is_ertn;
  logic        wb_is_refetch;
  logic        wb_is_idle;
  logic        ie;
  logic [11:0] lie;
  logic [11:0] is;
  logic        is_exc;
  logic [5:0]  excode;
  logic [8:0]  esubcode;
  logic [31:0] badvaddr;
  logic [31:0] csr_pc;
  logic        is_ertn;
  logic        is_fetch_again;
  logic        is_idle;
  logic        wb_commit;
  logic        flush;
  logic        idle_stall;

  modport master (
    input  wb_valid, wb_pc, wb_exc_valid, wb_excode, wb_esubcode, wb_badv,
           wb_is_ertn, wb_is_refetch, wb_is_idle, ie, lie, is,
    output is_exc, excode, esubcode, badvaddr, csr_pc, is_ertn,
           is_fetch_again, is_idle, wb_commit, flush, idle_stall
  );

  modport slave (
    output wb_valid, wb_pc, wb_exc_valid, wb_excode, wb_esubcode, wb_badv,
           wb_is_ertn, wb_is_refetch, wb_is_idle, ie, lie, is,
    input  is_exc, excode, esubcode, badvaddr, csr_pc, is_ertn,
           is_fetch_again, is_idle, wb_commit, flush, idle_stall
  );
endinterface

// File: rtl/exc_commit_ctrl_prio_sel.sv
// Combinational priority select: interrupt > exception > ertn > refetch > idle.
module exc_prio_sel
  import cpuDefine::*;
(
  input  logic        valid,
  input  logic        int_pending,
  input  logic        exc_valid,
  input  logic [5:0]  exc_code,
  input  logic [8:0]  exc_subcode,
  input  logic [31:0] exc_badv,
  input  logic        is_ertn,
  input  logic        is_refetch,
  input  logic        is_idle,
  output exc_event_t  ev,
  output logic [5:0]  ev_excode,
  output logic [8:0]  ev_esubcode,
  output logic [31:0] ev_badv
);

  always_comb begin
    ev          = '0;
    ev_excode   = '0;
    ev_esubcode = '0;
    ev_badv     = '0;
    if (valid) begin
      if (int_pending) begin
        ev.intr   = 1'b1;
        ev_excode = INT;
      end else if (exc_valid) begin
        ev.exc      = 1'b1;
        ev_excode   = exc_code;
        ev_esubcode = exc_subcode;
        ev_badv     = exc_badv;
      end else if (is_ertn) begin
        ev.ertn = 1'b1;
      end else if (is_refetch) begin
        ev.refetch = 1'b1;
      end else if (is_idle) begin
        ev.idle = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB commit/exception controller: event arbitration, idle wait and post-redirect drain.
module exc_commit_ctrl
  import cpuDefine::*;
#(
  parameter int EXC_DRAIN = 2
) (
  input logic clk,
  input logic reset,
  exc_commit_ctrl_if.master bus
);

  localparam int CNT_W = (EXC_DRAIN < 2) ? 1 : $clog2(EXC_DRAIN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXC_DRAIN);

  generate
    if (EXC_DRAIN < 1) begin : g_bad_drain
      $error("exc_commit_ctrl: EXC_DRAIN must be at least 1");
    end
  endgenerate

  exc_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      idle_pc_reg, idle_pc_next;

  logic [11:0] int_hit;
  logic        int_pending;
  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_int_hit
      assign int_hit[gi] = bus.lie[gi] & bus.is[gi];
    end
  endgenerate
  assign int_pending = bus.ie & (|int_hit);

  exc_event_t  ev;
  logic [5:0]  sel_excode;
  logic [8:0]  sel_esubcode;
  logic [31:0] sel_badv;
  logic        redirect;

  exc_prio_sel u_prio_sel (
    .valid       (bus.wb_valid && state_reg == RUN && !reset),
    .int_pending (int_pending),
    .exc_valid   (bus.wb_exc_valid),
    .exc_code    (bus.wb_excode),
    .exc_subcode (bus.wb_esubcode),
    .exc_badv    (bus.wb_badv),
    .is_ertn     (bus.wb_is_ertn),
    .is_refetch  (bus.wb_is_refetch),
    .is_idle     (bus.wb_is_idle),
    .ev          (ev),
    .ev_excode   (sel_excode),
    .ev_esubcode (sel_esubcode),
    .ev_badv     (sel_badv)
  );

  assign redirect = ev.intr | ev.exc | ev.ertn | ev.refetch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      idle_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idle_pc_reg <= idle_pc_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idle_pc_next = idle_pc_reg;
    case (state_reg)
      RUN: begin
        if (redirect) begin
          state_next = DRAIN;
          cnt_next   = CNT_LOAD;
        end else if (ev.idle) begin
          state_next   = IDLE;
          idle_pc_next = bus.wb_pc;
        end
      end
      IDLE: begin
        if (int_pending) begin
          state_next = DRAIN;
          cnt_next   = CNT_LOAD;
        end
      end
      DRAIN: begin
        // Counter value 1 marks the final drain cycle.
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

  logic        is_exc_c, is_ertn_c, is_fetch_again_c, is_idle_c;
  logic        wb_commit_c, flush_c, idle_stall_c;
  logic [5:0]  excode_c;
  logic [8:0]  esubcode_c;
  logic [31:0] badvaddr_c, csr_pc_c;

  always_comb begin
    is_exc_c         = 1'b0;
    is_ertn_c        = 1'b0;
    is_fetch_again_c = 1'b0;
    is_idle_c        = 1'b0;
    wb_commit_c      = 1'b0;
    flush_c          = 1'b0;
    idle_stall_c     = 1'b0;
    excode_c         = '0;
    esubcode_c       = '0;
    badvaddr_c       = '0;
    csr_pc_c         = '0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          is_exc_c         = ev.intr | ev.exc;
          is_ertn_c        = ev.ertn;
          is_fetch_again_c = ev.refetch;
          is_idle_c        = ev.idle;
          excode_c         = sel_excode;
          esubcode_c       = sel_esubcode;
          badvaddr_c       = sel_badv;
          csr_pc_c         = (ev.intr | ev.exc | ev.refetch | ev.idle) ? bus.wb_pc : 32'd0;
          wb_commit_c      = bus.wb_valid & ~(ev.intr | ev.exc);
          flush_c          = redirect;
        end
        IDLE: begin
          idle_stall_c = 1'b1;
          flush_c      = 1'b1;
          if (int_pending) begin
            is_exc_c = 1'b1;
            excode_c = INT;
            csr_pc_c = idle_pc_reg + 32'd4;
          end
        end
        DRAIN: flush_c = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.is_exc         = is_exc_c;
  assign bus.excode         = excode_c;
  assign bus.esubcode       = esubcode_c;
  assign bus.badvaddr       = badvaddr_c;
  assign bus.csr_pc         = csr_pc_c;
  assign bus.is_ertn        = is_ertn_c;
  assign bus.is_fetch_again = is_fetch_again_c;
  assign bus.is_idle        = is_idle_c;
  assign bus.wb_commit      = wb_commit_c;
  assign bus.flush          = flush_c;
  assign bus.idle_stall     = idle_stall_c;

endmodule

// File: doc/exc_commit_ctrl.md
# exc_commit_ctrl

Writeback-stage commit and exception controller: the initiator side of the CSR unit's exception interface. Once per retiring instruction it arbitrates interrupts, pipeline-detected exceptions, `ertn`, refetch and `idle`. It then drives the single-cycle event pulses and cause fields the CSR unit consumes, and flushes the pipeline. It also runs the idle wait state and post-redirect drain, so the CSR unit's registered `exaddr`/`exlike` land before new instructions retire.

## Interface
Parameters:
- `EXC_DRAIN`, default 2: cycles after any redirect event during which `wb_valid` is ignored and `flush` is held.

Ports (reset: synchronous, active-high; clock `clk`):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `wb_valid`  in  1  instruction present in WB
- `wb_pc`  in  32  PC of WB instruction
- `wb_exc_valid`  in  1  instruction carries a pipeline-detected exception
- `wb_excode`  in  6  cause code of that exception
- `wb_esubcode`  in  9  sub-code of that exception
- `wb_badv`  in  32  faulting address of that exception
- `wb_is_ertn`  in  1  instruction is `ertn`
- `wb_is_refetch`  in  1  instruction requires refetch of pc+4 (TLB ops, CSR writes)
- `wb_is_idle`  in  1  instruction is `idle`
- `ie`  in  1  CRMD.IE from CSR
- `lie`  in  12  local interrupt enables from CSR
- `is`  in  12  interrupt status from CSR
- `is_exc`  out  1  exception/interrupt pulse to CSR
- `excode`  out  6  cause code to CSR
- `esubcode`  out  9  sub-code to CSR
- `badvaddr`  out  32  bad address to CSR
- `csr_pc`  out  32  exception/refetch PC to CSR
- `is_ertn`  out  1  ertn pulse to CSR
- `is_fetch_again`  out  1  refetch pulse to CSR
- `is_idle`  out  1  idle-entry pulse to CSR
- `wb_commit`  out  1  WB instruction architecturally retires (gates GPR write, LL/SC, stores already committed)
- `flush`  out  1  kill IF..MEM
- `idle_stall`  out  1  freeze fetch while idling

## Operation
- `int_pending = ie & |(lie & is)`.
- States: `RUN`, `IDLE`, `DRAIN`. Reset → `RUN`, drain counter 0, idle PC 0.
- In `RUN` with `wb_valid`, one event is chosen, highest priority first:
  - **Interrupt** (`int_pending`):
    - `is_exc`=1, `excode`=INT (0x00), `esubcode`=0, `badvaddr`=0.
    - `csr_pc`=`wb_pc`, `wb_commit`=0.
  - **Exception** (`wb_exc_valid`):
    - `is_exc`=1, `excode`/`esubcode`/`badvaddr` passed through from `wb_*`.
    - `csr_pc`=`wb_pc`, `wb_commit`=0.
  - **Ertn** (`wb_is_ertn`): `is_ertn`=1, `wb_commit`=1.
  - **Refetch** (`wb_is_refetch`): `is_fetch_again`=1, `csr_pc`=`wb_pc`, `wb_commit`=1.
  - **Idle** (`wb_is_idle`):
    - `is_idle`=1, `csr_pc`=`wb_pc`, `wb_commit`=1.
    - Latch idle PC ← `wb_pc`; next state `IDLE`.
  - **None**: `wb_commit`=1, no pulse, stay `RUN`.
- After interrupt, exception, ertn or refetch: `flush`=1 that cycle; next state `DRAIN`, counter ← `EXC_DRAIN`.
- `IDLE`:
  - `idle_stall`=1, `flush`=1, `wb_valid` ignored.
  - On `int_pending`: `is_exc`=1, `excode`=0x00, `csr_pc`=idle PC + 4 (modulo 2^32). Next state `DRAIN`.
- `DRAIN`:
  - `flush`=1, `wb_valid` ignored, all pulses 0, `wb_commit`=0.
  - Counter decrements each cycle; leave for `RUN` when counter reaches 1.
- `excode`, `esubcode` and `badvaddr` are 0 whenever `is_exc`=0. This is required because the CSR unit selects the refill entry on `excode`==TLBR (0x3F) regardless of `is_exc`.
- At most one of `is_exc`, `is_ertn`, `is_fetch_again`, `is_idle` is high in any cycle.
- `csr_pc` is 0 when no pulse is active.

## Timing
- All outputs are combinational from the current state and inputs, so pulses coincide with the WB cycle of the instruction. State and counter are registered.
- Reset value of every output is 0. `reset` in any state forces `RUN` the next cycle and drops all outputs.
- A pulse lasts exactly 1 cycle. The CSR unit's redirect appears 1 cycle later; `EXC_DRAIN`≥1 covers that cycle.
- `is` and `ie` arrive registered (1 cycle stale). An interrupt that becomes visible during `DRAIN` is taken on the first `wb_valid` in `RUN`.
- `IDLE` wake latency: 0 cycles from `int_pending` visible to `is_exc`.
- Interrupt coinciding with `ertn`, `idle`, refetch or an exception: the interrupt wins and the instruction does not commit.
- Exception plus ertn on the same instruction: the exception wins.
- `EXC_DRAIN`=0 is illegal; this is a compile-time assertion.

## Structure
- `cpuDefine` package:
  - Add the `exc_state_t` enum (`RUN`/`IDLE`/`DRAIN`).
  - Reuse the existing excode constants; add `INT` = 6'h00 if absent.
- Sub-module `exc_prio_sel`: combinational priority select producing a one-hot event plus cause fields. The top level holds the FSM, drain counter and idle PC register.

## Test plan
- **ALE**: `wb_pc`=0x1C000100, `wb_excode`=0x09, `wb_badv`=0x00001003.
  - Same cycle: `is_exc`=1, `excode`=0x09, `badvaddr`=0x1003, `csr_pc`=0x1C000100, `wb_commit`=0.
  - `flush` high 3 cycles; `wb_valid` ignored for the 2 following cycles.
- **Interrupt vs. ertn**: `ie`=1, `lie[11]`=`is[11]`=1, ertn at 0x1C000200.
  - `is_exc`=1, `excode`=0x00, `is_ertn`=0, `csr_pc`=0x1C000200.
- **Ertn after TLBR**: TLBR exception (0x3F) is followed after drain by a plain ertn.
  - `is_ertn`=1, `excode`=0x00, `wb_commit`=1.
- **Idle**: idle at 0x1C000300.
  - `is_idle`=1 and `wb_commit`=1 for 1 cycle, then `idle_stall`=`flush`=1.
  - Raise `lie[2]`/`is[2]` with `ie`=1 after 10 cycles: `is_exc`=1, `csr_pc`=0x1C000304, then `DRAIN`→`RUN`.
- **Refetch**: refetch at 0x1C000400.
  - `is_fetch_again`=1, `csr_pc`=0x1C000400, `wb_commit`=1.
  - Back-to-back `wb_valid` is suppressed for 2 cycles.
- **Reset in `IDLE`/`DRAIN`**:
  - All outputs 0 the next cycle.
  - The next `wb_valid` with no events commits normally (`wb_commit`=1).
